// File: rtl/pipelined_ripple_adder_pkg.sv
// adder_pkg: shared constants and helpers for the pipelined ripple adder.
//   SEG_DEF     - default segment width (bits added per pipeline stage)
//   calc_stages - pipeline depth for a given operand width and segment width
//   seg_ok      - true when the operand width splits evenly into segments
package adder_pkg;

  localparam int SEG_DEF = 4;

  function automatic int calc_stages(input int n, input int seg);
    return n / seg;
  endfunction

  function automatic bit seg_ok(input int n, input int seg);
    return (seg > 0) && (n >= seg) && ((n % seg) == 0);
  endfunction

endpackage

// File: rtl/pipelined_ripple_adder_if.sv
// pipelined_ripple_adder_if: valid/ready operand and result bus of the adder.
//   in_valid/in_ready/in1/in2/cin : operand side (producer -> adder)
//   out_valid/out_ready/sum/cout  : result side (adder -> consumer)
//   ovf                           : signed overflow, present only with ADDER_OVF_EN
// Modports: master = producer/consumer side, slave = adder side.
interface pipelined_ripple_adder_if #(parameter int N = 16);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
`ifdef ADDER_OVF_EN
  logic         ovf;

  modport master (output in_valid, in1, in2, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, in1, in2, cin, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`else
  modport master (output in_valid, in1, in2, cin, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, in1, in2, cin, out_ready,
                  output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/pipelined_ripple_adder_seg.sv
// fa        : single-bit full adder cell.
// adder_seg : combinational SEG-bit ripple chain of fa cells.
//   in1, in2  - SEG-bit operand slices
//   cin       - carry into bit 0 of the slice
//   sum       - SEG-bit sum slice
//   cout      - carry out of the top bit of the slice
//   msb_carry - carry into the top bit of the slice (signed overflow detection)
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_seg #(parameter int SEG = 4) (
  input  logic [SEG-1:0] in1,
  input  logic [SEG-1:0] in2,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           msb_carry
);
  logic [SEG:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    fa u_fa (.a(in1[i]), .b(in2[i]), .ci(w_c[i]), .s(sum[i]), .co(w_c[i+1]));
  end

  assign cout      = w_c[SEG];
  assign msb_carry = w_c[SEG-1];
endmodule

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: N-bit ripple-carry adder cut into SEG-bit segments,
// one register stage per segment, valid/ready handshake with backpressure.
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - pipelined_ripple_adder_if.slave (operands in, {cout,sum} out)
// Latency STAGES = N/SEG cycles, one result per cycle.
// Optional: ADDER_OVF_EN adds a registered signed-overflow flag (bus.ovf).
module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int N   = 16,
  parameter int SEG = SEG_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  pipelined_ripple_adder_if.slave  bus
);
  localparam int STAGES = calc_stages(N, SEG);

  if (!seg_ok(N, SEG)) begin : g_bad_seg
    $error("pipelined_ripple_adder: N must be a positive multiple of SEG");
  end

  // Per-stage state, gathered into arrays so neighbouring stages can see it.
  logic [STAGES-1:0]        w_vld;
  logic [STAGES-1:0][N-1:0] w_sum;
  logic [STAGES-1:0][N-1:0] w_a;
  logic [STAGES-1:0][N-1:0] w_b;
  logic [STAGES-1:0]        w_c;
  logic [STAGES-1:0]        w_co;
  logic [STAGES-1:0]        w_msb;
  logic [STAGES-1:0]        w_ld;
  // w_rdy[k]: stage k can take a new item this cycle; the top entry is the consumer.
  logic [STAGES:0]          w_rdy;

  assign w_rdy[STAGES] = bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic         w_src_vld;
    logic [N-1:0] w_src_a;
    logic [N-1:0] w_src_b;
    logic [N-1:0] w_src_sum;
    logic         w_ci;
    logic [SEG-1:0] w_s;

    logic         r_v;
    logic [N-1:0] r_s;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic         r_c;

    if (k == 0) begin : g_head
      assign w_src_vld = bus.in_valid;
      assign w_src_a   = bus.in1;
      assign w_src_b   = bus.in2;
      assign w_ci      = bus.cin;
      assign w_src_sum = '0;
    end else begin : g_body
      assign w_src_vld = w_vld[k-1];
      assign w_src_a   = w_a[k-1];
      assign w_src_b   = w_b[k-1];
      assign w_ci      = w_c[k-1];
      assign w_src_sum = w_sum[k-1];
    end

    adder_seg #(.SEG(SEG)) u_seg (
      .in1       (w_src_a[k*SEG +: SEG]),
      .in2       (w_src_b[k*SEG +: SEG]),
      .cin       (w_ci),
      .sum       (w_s),
      .cout      (w_co[k]),
      .msb_carry (w_msb[k])
    );

    // Empty stages fill bubbles even while the output is stalled.
    assign w_rdy[k] = !r_v || w_rdy[k+1];
    assign w_ld[k]  = w_rdy[k] && w_src_vld;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= 1'b0;
        r_s <= '0;
        r_a <= '0;
        r_b <= '0;
        r_c <= 1'b0;
      end else begin
        // When ready, the stage either takes the upstream item or drains to empty.
        if (w_rdy[k]) r_v <= w_src_vld;
        if (w_ld[k]) begin
          r_s              <= w_src_sum;
          r_s[k*SEG +: SEG] <= w_s;
          r_c              <= w_co[k];
          r_a              <= w_src_a;
          r_b              <= w_src_b;
        end
      end
    end

    assign w_vld[k] = r_v;
    assign w_sum[k] = r_s;
    assign w_a[k]   = r_a;
    assign w_b[k]   = r_b;
    assign w_c[k]   = r_c;
  end

  assign bus.in_ready  = w_rdy[0];
  assign bus.out_valid = w_vld[STAGES-1];
  assign bus.sum       = w_sum[STAGES-1];
  assign bus.cout      = w_c[STAGES-1];

`ifdef ADDER_OVF_EN
  // Overflow = carry into the MSB xor carry out of it, both from the last segment.
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_ovf <= 1'b0;
    else if (w_ld[STAGES-1]) r_ovf <= w_msb[STAGES-1] ^ w_co[STAGES-1];
  end

  assign bus.ovf = r_ovf;
`endif
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed + random self-checking bench for pipelined_ripple_adder (N=16, SEG=4).
module tb_pipelined_ripple_adder;
  logic clk = 1'b0;
  logic rst;
  int   n_vec;
  int   n_err;

  pipelined_ripple_adder_if #(.N(16)) bus ();

  pipelined_ripple_adder #(.N(16), .SEG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one operand set into an idle pipe and wait (bounded) for its result.
  task automatic push1(input logic [15:0] a, input logic [15:0] b, input logic c,
                       output logic [16:0] res, output int lat);
    bus.in_valid = 1'b1;
    bus.in1 = a;
    bus.in2 = b;
    bus.cin = c;
    #1;
    chk("push_rdy", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 12) begin
      tick();
      lat++;
    end
    res = {bus.cout, bus.sum};
  endtask

  logic [15:0] a2 [3];
  logic [15:0] b2 [3];
  logic        c2 [3];
  logic [16:0] e2 [3];
  logic [15:0] a3 [6];
  logic [15:0] b3 [6];
  logic        c3 [6];
  logic [16:0] e3 [6];
  logic [16:0] q [$];

  initial begin
    logic [16:0] res;
    int          lat;
    int          acc;
    int          got;

    a2 = '{16'h1234, 16'h00FF, 16'h8000};
    b2 = '{16'h1111, 16'h0001, 16'h8000};
    c2 = '{1'b0, 1'b0, 1'b1};
    e2 = '{17'h02345, 17'h00100, 17'h10001};

    a3 = '{16'h0001, 16'hF000, 16'h0FFF, 16'hAAAA, 16'h1234, 16'hFFFF};
    b3 = '{16'h0002, 16'h1000, 16'h0000, 16'h5555, 16'h4321, 16'hFFFF};
    c3 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    e3 = '{17'h00003, 17'h10000, 17'h01000, 17'h10000, 17'h05555, 17'h1FFFF};

    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_ovld", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_irdy", bus.in_ready, 1);
`ifdef ADDER_OVF_EN
    chk("rst_ovf", bus.ovf, 0);
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Full-width carry propagation, latency exactly 4
    push1(16'hFFFF, 16'h0001, 1'b0, res, lat);
    chk("t1_lat", lat, 4);
    chk("t1_res", res, 17'h10000);
    tick();

    // Back-to-back stream, no bubbles
    for (int c = 0; c < 7; c++) begin
      if (c < 3) begin
        bus.in_valid = 1'b1;
        bus.in1 = a2[c];
        bus.in2 = b2[c];
        bus.cin = c2[c];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (c < 3) chk("t2_irdy", bus.in_ready, 1);
      if (c >= 4) begin
        chk("t2_ovld", bus.out_valid, 1);
        chk("t2_res", {bus.cout, bus.sum}, e2[c-4]);
      end
      tick();
    end
    chk("t2_empty", bus.out_valid, 0);

`ifdef ADDER_OVF_EN
    push1(16'h7FFF, 16'h0001, 1'b0, res, lat);
    chk("ovf1_res", res, 17'h08000);
    chk("ovf1_ovf", bus.ovf, 1);
    tick();
    push1(16'hFFFF, 16'h0001, 1'b0, res, lat);
    chk("ovf2_res", res, 17'h10000);
    chk("ovf2_ovf", bus.ovf, 0);
    tick();
`endif

    // Backpressure: fill, hold first result, then drain in order
    bus.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 7; c++) begin
      bus.in_valid = (acc < 6);
      if (acc < 6) begin
        bus.in1 = a3[acc];
        bus.in2 = b3[acc];
        bus.cin = c3[acc];
      end
      #1;
      if (bus.in_valid && bus.in_ready) acc++;
      if (c >= 4) begin
        chk("t3_hold_v", bus.out_valid, 1);
        chk("t3_hold", {bus.cout, bus.sum}, e3[0]);
      end
      tick();
    end
    chk("t3_accepts", acc, 4);
    chk("t3_irdy_low", bus.in_ready, 0);

    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      bus.in_valid = (acc < 6);
      if (acc < 6) begin
        bus.in1 = a3[acc];
        bus.in2 = b3[acc];
        bus.cin = c3[acc];
      end
      #1;
      if (bus.out_valid && bus.out_ready) begin
        chk("t3_drain", {bus.cout, bus.sum}, e3[got]);
        got++;
      end
      if (bus.in_valid && bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t3_got", got, 6);
    chk("t3_acc", acc, 6);
    chk("t3_empty", bus.out_valid, 0);

    // Random traffic against a reference sum, in order
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in1       = 16'($urandom);
      bus.in2       = 16'($urandom);
      bus.cin       = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("rnd_extra", 1, 0);
        else chk("rnd", {bus.cout, bus.sum}, q.pop_front());
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back({1'b0, bus.in1} + {1'b0, bus.in2} + {16'd0, bus.cin});
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.out_valid) begin
        if (q.size() == 0) chk("rnd_extra", 1, 0);
        else chk("rnd_drain", {bus.cout, bus.sum}, q.pop_front());
      end
      tick();
    end
    chk("rnd_left", q.size(), 0);

    // Reset with three items in flight
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1'b1;
      bus.in1 = a3[c];
      bus.in2 = b3[c];
      bus.cin = c3[c];
      #1;
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("t4_ovld", bus.out_valid, 0);
    chk("t4_sum", bus.sum, 0);
    chk("t4_irdy", bus.in_ready, 1);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("t4_stale", bus.out_valid, 0);
      tick();
    end
    chk("t4_irdy2", bus.in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
